fetch_unit: RTL and testbench

- Instruction-fetch stage; sits directly upstream of decode and the immediate extender. The extender consumes if_instr[31:7].
- Holds the PC and issues one request at a time to instruction memory (req/gnt, then rvalid).
- Presents each fetched word, with its PC and PC+4, to decode over a valid/ready handshake.
- Takes taken-branch/jump redirects from execute and discards stale in-flight responses.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_pc_gen.sv | 65 ++++++
 rtl/fetch_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the instruction-fetch stage
//
// Purpose: one place for the datapath width, the reset PC default, the NOP
// encoding presented to decode when no instruction is held, and the fetch
// FSM state encoding.
package riscv_pkg;

  // Address/data width; the fetch path is written for 32 bits only.
  localparam int unsigned XLEN = 32;

  // Default PC loaded on reset when the top is not overridden.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM: ISSUE drives a request, WAIT holds for the response,
  // HOLD presents a word to decode until it is taken.
  typedef enum logic [1:0] {
    FS_ISSUE = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC register with redirect / +4 / hold next-PC mux
//
// Purpose: owns the architectural fetch PC and the PC of the single
// outstanding memory request. The FSM in fetch_unit tells it when a request
// is granted (issue_i) and when a response is consumed (advance_i).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   redirect_i            load redirect_pc_i into pc (highest priority)
//   redirect_pc_i         already-masked redirect target
//   issue_i               request granted this cycle: snapshot pc
//   advance_i             response accepted: pc <= pc_inflight + 4
//   pc_o                  current fetch PC
//   pc_inflight_o         PC of the request in flight
//   pc_inflight_plus4_o   pc_inflight + 4, modulo 2^XLEN
module fetch_pc_gen #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            issue_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inflight_o,
  output logic [XLEN-1:0] pc_inflight_plus4_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
  logic [XLEN-1:0] inflight_plus4;

  // Wraps naturally at the top of the address space.
  assign inflight_plus4 = pc_inflight_q + XLEN'(4);

  always_comb begin
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (advance_i) begin
      pc_d = inflight_plus4;
    end
    if (issue_i) begin
      pc_inflight_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
    end
  end

  assign pc_o                = pc_q;
  assign pc_inflight_o       = pc_inflight_q;
  assign pc_inflight_plus4_o = inflight_plus4;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: one outstanding imem request, valid/ready to decode
//
// Purpose: issues word-aligned fetches one at a time (req/gnt then rvalid),
// registers each returned word with its PC and PC+4 for decode, and applies
// execute redirects, discarding any response that belongs to a squashed fetch.
//
// Optional feature: FETCH_MISALIGN_CHK_EN. When defined, a redirect to a
// target with nonzero low bits issues no fetch; instead a NOP is presented
// with if_misalign=1 and the raw target in if_pc, and the stage then idles in
// HOLD until the next redirect. When undefined, redirect_pc[1:0] is ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request, word-aligned address
//   imem_gnt          request accepted
//   imem_rvalid/rdata response
//   redirect_valid/pc PC redirect from execute (highest priority)
//   if_valid/id_ready handshake to decode
//   if_instr/pc/pc_plus4  instruction, its PC and PC+4
//   if_misalign       (FETCH_MISALIGN_CHK_EN only) misaligned redirect trap
module fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            if_misalign,
`endif
  output logic [XLEN-1:0] if_pc_plus4
);

  import riscv_pkg::*;

  localparam logic [1:0] ISSUE = FS_ISSUE;
  localparam logic [1:0] WAIT  = FS_WAIT;
  localparam logic [1:0] HOLD  = FS_HOLD;

  logic [1:0]      state_q, state_d;
  logic            kill_q, kill_d;
  logic            trap_q, trap_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_pc4_q, out_pc4_d;

  logic            issue;
  logic            advance;
  logic            redirect_bad;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inflight;
  logic [XLEN-1:0] pc_inflight_plus4;

  // Fetch targets are always word aligned.
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_bad        = 1'b0;
`endif

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk                 (clk),
    .rst_n               (rst_n),
    .redirect_i          (redirect_valid),
    .redirect_pc_i       (redirect_tgt),
    .issue_i             (issue),
    .advance_i           (advance),
    .pc_o                (pc),
    .pc_inflight_o       (pc_inflight),
    .pc_inflight_plus4_o (pc_inflight_plus4)
  );

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    trap_d    = trap_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    out_pc4_d = out_pc4_q;
    issue     = 1'b0;
    advance   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      ISSUE: begin
        // A grant always starts a memory transaction; if a redirect lands in
        // the same cycle the response must still be drained, but dropped.
        issue = imem_gnt;
        if (imem_gnt) begin
          state_d = WAIT;
          kill_d  = redirect_valid;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          // Response retires the transaction; it is only delivered when no
          // redirect has touched this fetch.
          state_d = ISSUE;
          kill_d  = 1'b0;
          if (!redirect_valid && !kill_q) begin
            state_d   = HOLD;
            valid_d   = 1'b1;
            instr_d   = imem_rdata;
            out_pc_d  = pc_inflight;
            out_pc4_d = pc_inflight_plus4;
            advance   = 1'b1;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Squash the held word even if decode is taking it this cycle.
          valid_d = 1'b0;
          trap_d  = 1'b0;
          state_d = ISSUE;
`ifdef FETCH_MISALIGN_CHK_EN
          misalign_d = 1'b0;
`endif
        end else if (id_ready) begin
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
          misalign_d = 1'b0;
`endif
          // After a misalign trap the stage parks until execute redirects.
          if (!trap_q) begin
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = ISSUE;
        kill_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    // A misaligned redirect overrides everything above: no fetch, just a
    // marked NOP for decode to raise the exception on.
    if (redirect_bad) begin
      state_d   = HOLD;
      kill_d    = 1'b0;
      trap_d    = 1'b1;
      valid_d   = 1'b1;
      instr_d   = NOP_INSTR;
      out_pc_d  = redirect_pc;
      out_pc4_d = redirect_pc + XLEN'(4);
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ISSUE;
      kill_q    <= 1'b0;
      trap_q    <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      out_pc_q  <= '0;
      out_pc4_q <= '0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      trap_q    <= trap_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      out_pc_q  <= out_pc_d;
      out_pc4_q <= out_pc4_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign if_misalign = misalign_q;
`endif

  // Gated with rst_n so no request is shown while reset is held.
  assign imem_req    = rst_n && (state_q == ISSUE);
  assign imem_addr   = pc & ~XLEN'(3);
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = out_pc_q;
  assign if_pc_plus4 = out_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed cases then randomized traffic against a stream model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_CHK_EN
    .if_misalign    (if_misalign),
`endif
    .if_pc_plus4    (if_pc_plus4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Inputs set after cyc() take effect on the following rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
  endtask

  // Random-phase model state: the next PC the instruction stream must carry.
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic [31:0] tgt;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        pend;
  logic        hold_chk;
  int          cnt;
  int          delivered;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_instr", if_instr, NOP);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_pc4", if_pc_plus4, 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", imem_addr, 32'h0);

    // First fetch: gnt in ISSUE, rvalid next cycle, decode ready.
    imem_gnt = 1'b1;
    cyc();
    check_eq("wait_req", 32'(imem_req), 32'd0);
    check_eq("wait_valid", 32'(if_valid), 32'd0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    id_ready    = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("t1_valid", 32'(if_valid), 32'd1);
    check_eq("t1_instr", if_instr, 32'h0050_0093);
    check_eq("t1_pc", if_pc, 32'h0);
    check_eq("t1_pc4", if_pc_plus4, 32'h4);
    cyc();
    check_eq("t1_drop", 32'(if_valid), 32'd0);
    check_eq("t1_next_req", 32'(imem_req), 32'd1);
    check_eq("t1_next_addr", imem_addr, 32'h4);

    // Decode stalls for 5 cycles in HOLD.
    id_ready = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    cyc();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(if_valid), 32'd1);
      check_eq("stall_instr", if_instr, 32'h00A0_0113);
      check_eq("stall_pc", if_pc, 32'h4);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      cyc();
    end
    check_eq("stall6_valid", 32'(if_valid), 32'd1);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    check_eq("stall_done", 32'(if_valid), 32'd0);
    check_eq("stall_next_addr", imem_addr, 32'h8);

    // A stray response in ISSUE must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADB_AD00;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("stray_valid", 32'(if_valid), 32'd0);
    check_eq("stray_req", 32'(imem_req), 32'd1);
    check_eq("stray_addr", imem_addr, 32'h8);

    // Redirect in WAIT, response two cycles later is dropped.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    check_eq("kill_wait_valid", 32'(if_valid), 32'd0);
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("kill_valid", 32'(if_valid), 32'd0);
    check_eq("kill_req", 32'(imem_req), 32'd1);
    check_eq("kill_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as rvalid.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    check_eq("samecyc_valid", 32'(if_valid), 32'd0);
    check_eq("samecyc_req", 32'(imem_req), 32'd1);
    check_eq("samecyc_addr", imem_addr, 32'h200);

    // Redirect in HOLD while decode is ready: held word is squashed.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0030_0193;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("hold_valid", 32'(if_valid), 32'd1);
    check_eq("hold_pc", if_pc, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    id_ready       = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    check_eq("squash_valid", 32'(if_valid), 32'd0);
    check_eq("squash_req", 32'(imem_req), 32'd1);
    check_eq("squash_addr", imem_addr, 32'h300);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cyc();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("mis_valid", 32'(if_valid), 32'd1);
    check_eq("mis_flag", 32'(if_misalign), 32'd1);
    check_eq("mis_pc", if_pc, 32'h102);
    check_eq("mis_instr", if_instr, NOP);
    check_eq("mis_req", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    cyc();
    check_eq("mis_taken_valid", 32'(if_valid), 32'd0);
    check_eq("mis_park_req", 32'(imem_req), 32'd0);
    cyc();
    check_eq("mis_park_req2", 32'(imem_req), 32'd0);
    id_ready = 1'b0;
`else
    check_eq("mask_req", 32'(imem_req), 32'd1);
    check_eq("mask_addr", imem_addr, 32'h100);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cyc();
    redirect_valid = 1'b0;
    check_eq("redir400_req", 32'(imem_req), 32'd1);
    check_eq("redir400_addr", imem_addr, 32'h400);
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("mis_cleared", 32'(if_misalign), 32'd0);
`endif

    // Fetch at the top of the address space wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    id_ready    = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("wrap_valid", 32'(if_valid), 32'd1);
    check_eq("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", if_pc_plus4, 32'h0);
    cyc();
    id_ready = 1'b0;
    check_eq("wrap_next_addr", imem_addr, 32'h0);
    check_eq("wrap_next_req", 32'(imem_req), 32'd1);

    // Asynchronous reset while holding an instruction.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    check_eq("pre_arst_valid", 32'(if_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(if_valid), 32'd0);
    check_eq("arst_instr", if_instr, NOP);
    check_eq("arst_pc", if_pc, 32'h0);
    check_eq("arst_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic: the delivered stream must follow the PC sequence
    // implied by redirects and acceptances, with data from the memory image.
    exp_pc    = 32'h0;
    pend      = 1'b0;
    pend_addr = 32'h0;
    cnt       = 0;
    hold_chk  = 1'b0;
    hold_instr = 32'h0;
    hold_pc   = 32'h0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_chk) begin
        check_eq("rnd_hold_valid", 32'(if_valid), 32'd1);
        check_eq("rnd_hold_instr", if_instr, hold_instr);
        check_eq("rnd_hold_pc", if_pc, hold_pc);
      end
      check_eq("rnd_req_in_hold", 32'(imem_req & if_valid), 32'd0);

      imem_gnt    = ($urandom_range(0, 3) != 0);
      id_ready    = ($urandom_range(0, 2) != 0);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end
      redirect_valid = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_CHK_EN
      tgt[1:0] = 2'b00;
`endif
      redirect_pc = tgt;

      if (pend && imem_rvalid) pend = 1'b0;
      if (imem_req && imem_gnt) begin
        check_eq("rnd_grant_addr", imem_addr, exp_pc);
        pend      = 1'b1;
        pend_addr = imem_addr;
        cnt       = $urandom_range(0, 2);
      end
      if (if_valid && id_ready && !redirect_valid) begin
        check_eq("rnd_pc", if_pc, exp_pc);
        check_eq("rnd_instr", if_instr, mem_word(exp_pc));
        check_eq("rnd_pc4", if_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      hold_chk   = if_valid && !id_ready && !redirect_valid;
      hold_instr = if_instr;
      hold_pc    = if_pc;
      if (redirect_valid) exp_pc = tgt & ~32'd3;
      cyc();
    end
    check_eq("rnd_liveness", 32'(delivered >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
